// File: rtl/alu_iter_exec_pkg.sv
// Shared definitions for the alu_iter_exec execute unit.
// - ALUop codes shared with the ALU decoder
// - FSM state and serial-shift kind encodings
// - helper to map a shift ALUop onto a shift kind
package alu_iter_exec_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD    = 4'h0;
  localparam alu_op_t ALU_SUB    = 4'h1;
  localparam alu_op_t ALU_AND    = 4'h2;
  localparam alu_op_t ALU_OR     = 4'h3;
  localparam alu_op_t ALU_XOR    = 4'h4;
  localparam alu_op_t ALU_SLT    = 4'h5;
  localparam alu_op_t ALU_SLTU   = 4'h6;
  localparam alu_op_t ALU_SLL    = 4'h7;
  localparam alu_op_t ALU_SRL    = 4'h8;
  localparam alu_op_t ALU_SRA    = 4'h9;
  localparam alu_op_t ALU_COPY_B = 4'hA;
  localparam alu_op_t ALU_XXX    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift_op(alu_op_t op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic shift_kind_e to_shift_kind(alu_op_t op);
    shift_kind_e k;
    case (op)
      ALU_SRL: k = SH_SRL;
      ALU_SRA: k = SH_SRA;
      default: k = SH_SLL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_iter_exec_if.sv
// Request/response bus of the alu_iter_exec unit.
// Request side : in_valid, in_ready, ALUop, a, b
// Response side: out_valid, out_ready, result
// master = producer/consumer (bench or pipeline), slave = execute unit.
interface alu_iter_exec_if
  import alu_iter_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  alu_op_t          ALUop;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, ALUop, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, ALUop, a, b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter used by alu_iter_exec.
// Ports:
//   clk, reset : clock, async active-high reset
//   load       : capture din/shamt/kind (overrides any running shift)
//   kind       : SLL / SRL / SRA
//   shamt      : number of single-bit steps to perform
//   din        : value to shift
//   done       : the current cycle performs the final step
//   dout       : register value after one more step (the final result when done=1)
module alu_serial_shifter
  import alu_iter_exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  shift_kind_e        kind,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  shift_kind_e        kind_q, kind_d;
  logic [WIDTH-1:0]   step;

  always_comb begin
    case (kind_q)
      SH_SLL:  step = {shreg_q[WIDTH-2:0], 1'b0};
      SH_SRL:  step = {1'b0, shreg_q[WIDTH-1:1]};
      SH_SRA:  step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: step = shreg_q;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
    if (load) begin
      shreg_d = din;
      cnt_d   = shamt;
      kind_d  = kind;
    end else if (cnt_q != '0) begin
      // Keeps counting down after a flush; harmless since the next load overrides it.
      shreg_d = step;
      cnt_d   = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      kind_q  <= SH_SLL;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
    end
  end

  assign done = (cnt_q == SHAMT_W'(1));
  assign dout = step;

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle ops registered with latency 1, shifts done serially.
// Ports:
//   clk, reset : clock, async active-high reset
//   flush      : kills any held or in-flight op; no accept in a flush cycle
//   bus        : request/response handshake (slave side)
//   busy       : unit is not idle
module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  alu_iter_exec_if.slave bus,
  output logic          busy
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             sh_load;
  logic             sh_done;
  logic [WIDTH-1:0] sh_dout;

  function automatic logic [WIDTH-1:0] alu_comb(alu_op_t op, logic [WIDTH-1:0] x,
                                                logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      ALU_ADD:    r = x + y;
      ALU_SUB:    r = x - y;
      ALU_AND:    r = x & y;
      ALU_OR:     r = x | y;
      ALU_XOR:    r = x ^ y;
      ALU_SLT:    r = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
      ALU_SLTU:   r = {{(WIDTH-1){1'b0}}, x < y};
      ALU_COPY_B: r = y;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // DONE with out_ready lets a new op in on the same edge the old result leaves.
  assign bus.in_ready = !flush && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .kind  (to_shift_kind(bus.ALUop)),
    .shamt (bus.b[SHAMT_W-1:0]),
    .din   (bus.a),
    .done  (sh_done),
    .dout  (sh_dout)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sh_load     = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        if (sh_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = sh_dout;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (is_shift_op(bus.ALUop)) begin
        sh_load = 1'b1;
        if (bus.b[SHAMT_W-1:0] == '0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = bus.a;
        end else begin
          state_d     = ST_SHIFT;
          out_valid_d = 1'b0;
        end
      end else begin
        state_d     = ST_DONE;
        out_valid_d = 1'b1;
        result_d    = alu_comb(bus.ALUop, bus.a, bus.b);
      end
    end

    // Flush wins over everything; the last visible result is kept.
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed self-checking bench for alu_iter_exec.
module tb_alu_iter_exec;
  import alu_iter_exec_pkg::*;

  logic clk;
  logic reset;
  logic flush;
  logic busy;

  int checks;
  int errors;

  alu_iter_exec_if #(.WIDTH(32)) bus ();

  alu_iter_exec #(
    .WIDTH   (32),
    .SHAMT_W (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-shift op with out_ready=1: result one cycle after accept, then back to idle.
  task automatic run_single(input string tag, input alu_op_t op, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] exp);
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.a        = av;
    bus.b        = bv;
    #1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_result"}, bus.result, exp);
    tick();
    chk({tag, "_idle"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  // Shift op with out_ready=1: counts cycles from accept to out_valid.
  task automatic run_shift(input string tag, input alu_op_t op, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] exp,
                           input int exp_lat);
    int  cyc;
    logic rdy_seen;
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.a        = av;
    bus.b        = bv;
    #1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc      = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && cyc < 64) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_ready_low"}, {31'd0, rdy_seen}, 32'd0);
    chk({tag, "_result"}, bus.result, exp);
    tick();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic seen;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ALUop     = ALU_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Single-cycle ops
    run_single("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
    run_single("sub_wrap", ALU_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF);
    run_single("slt", ALU_SLT, 32'hFFFF_FFFE, 32'h1, 32'h1);
    run_single("sltu", ALU_SLTU, 32'hFFFF_FFFE, 32'h1, 32'h0);
    run_single("copy_b", ALU_COPY_B, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
    run_single("undef", ALU_XXX, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
    run_single("or", ALU_OR, 32'h0000_1234, 32'h00AB_0000, 32'h00AB_1234);

    // Serial shifts
    run_shift("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_shift("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_shift("sll0", ALU_SLL, 32'h1, 32'd0, 32'h1, 1);
    run_shift("sll4_hi_b", ALU_SLL, 32'h3, 32'hFFFF_FFE4, 32'h30, 5);

    // Back-pressure on a held XOR result, then back-to-back accept
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.ALUop     = ALU_XOR;
    bus.a         = 32'hFF00_FF00;
    bus.b         = 32'h0F0F_0F0F;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_result", bus.result, 32'hF00F_F00F);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.ALUop    = ALU_AND;
    bus.a        = 32'hF0;
    bus.b        = 32'h3C;
    #1;
    chk("bp_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("b2b_result", bus.result, 32'h30);
    tick();
    chk("b2b_idle", {31'd0, bus.out_valid}, 32'd0);

    // Flush three cycles into SLL by 20
    bus.in_valid = 1'b1;
    bus.ALUop    = ALU_SLL;
    bus.a        = 32'h1;
    bus.b        = 32'd20;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("fl_shift_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("fl_no_valid", {31'd0, seen}, 32'd0);
    chk("fl_result_kept", bus.result, 32'h30);

    // Flush together with in_valid
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.ALUop    = ALU_ADD;
    bus.a        = 32'd2;
    bus.b        = 32'd3;
    #1;
    chk("fl_acc_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_acc_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("fl_acc_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_acc_result", bus.result, 32'h30);

    // Flush while a result is held in DONE
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.ALUop     = ALU_OR;
    bus.a         = 32'h0000_1234;
    bus.b         = 32'h00AB_0000;
    tick();
    bus.in_valid = 1'b0;
    chk("fl_done_valid", {31'd0, bus.out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    chk("fl_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_done_busy", {31'd0, busy}, 32'd0);
    chk("fl_done_result", bus.result, 32'h00AB_1234);

    // Asynchronous reset mid-shift
    bus.in_valid = 1'b1;
    bus.ALUop    = ALU_SRA;
    bus.a        = 32'h8000_0000;
    bus.b        = 32'd10;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_single("post_rst_add", ALU_ADD, 32'd5, 32'd6, 32'd11);
    run_shift("post_rst_srl", ALU_SRL, 32'hF0, 32'd4, 32'hF, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
